// File: rtl/vic_pkg.sv
// vic_pkg -- shared types and constants for the Q-bus vectored-interrupt arbiter.
//   vicState_t  : arbiter bus-cycle FSM states
//   VEC_W       : interrupt vector width
//   IDX_W       : requester index width (up to 8 requesters)
//   CSR_ADR_DEF : default word address [15:3] of the mask CSR
//   vecOf()     : vector for a channel index, base + 4*index
package vic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VECT,
      RPLY,
      PASS,
      CSR_RD,
      CSR_WR
   } vicState_t;

   localparam int unsigned VEC_W       = 8;
   localparam int unsigned IDX_W       = 3;
   localparam logic [12:0] CSR_ADR_DEF = 13'o17760;

   function automatic logic [VEC_W-1:0] vecOf(input logic [VEC_W-1:0] base,
                                              input logic [IDX_W-1:0] idx);
      return base + {3'b000, idx, 2'b00};
   endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// vic_prio_enc -- fixed-priority encoder, lowest set index wins.
//   req   in  N      request vector
//   valid out 1      at least one request bit set
//   idx   out IDX_W  index of the lowest set bit (0 when none set)
module vic_prio_enc
   import vic_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !valid) begin
            valid = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/vic_qbus_arb.sv
// vic_qbus_arb -- vectored-interrupt arbiter for N requesters on the Q-bus.
// Latches falling edges of the request lines, raises nVIRQ, answers the
// interrupt-acknowledge read (nDIN + nIAKI) with the winner's vector and
// nRPLY, and passes the daisy chain on nIAKO when nothing is pending.
// Optional mask CSR is built when the macro VIC_CSR_EN is defined.
//   PIN_CLK      in   system clock
//   PIN_nRST     in   async reset, active low
//   PIN_nREQ     in   N  interrupt requests, active low, asynchronous
//   PIN_ACK      out  N  one-clock grant pulse to the served channel
//   PIN_nVIRQ    out  bus interrupt request, active low
//   PIN_nIAKI    in   daisy-chain acknowledge in
//   PIN_nIAKO    out  daisy-chain acknowledge out
//   PIN_nSYNC    in   bus address strobe (CSR only)
//   PIN_nDIN     in   bus read strobe
//   PIN_nDOUT    in   bus write strobe (CSR only)
//   PIN_nAD_IN   in   16 bus AD, inverted
//   PIN_nAD_OUT  out  16 bus AD drive value, inverted
//   PIN_AD_OE    out  AD output enable
//   PIN_nRPLY    out  bus reply, active low
module vic_qbus_arb
   import vic_pkg::*;
#(
   parameter int unsigned      N        = 4,
   parameter logic [VEC_W-1:0] VEC_BASE = 8'o060,
   parameter logic [12:0]      CSR_ADR  = CSR_ADR_DEF
) (
   input  logic         PIN_CLK,
   input  logic         PIN_nRST,
   input  logic [N-1:0] PIN_nREQ,
   output logic [N-1:0] PIN_ACK,
   output logic         PIN_nVIRQ,
   input  logic         PIN_nIAKI,
   output logic         PIN_nIAKO,
   input  logic         PIN_nSYNC,
   input  logic         PIN_nDIN,
   input  logic         PIN_nDOUT,
   input  logic [15:0]  PIN_nAD_IN,
   output logic [15:0]  PIN_nAD_OUT,
   output logic         PIN_AD_OE,
   output logic         PIN_nRPLY
);

   vicState_t        state, stateNext;
   logic [N-1:0]     reqS1, reqS2, reqPrev;
   logic             iakiS1, iakiS2, dinS1, dinS2;
   logic [N-1:0]     pend, mask, fall, ackSet, ackReg;
   logic             nVirqReg, encValid, loadWin;
   logic [IDX_W-1:0] encIdx, win;
   logic [15:0]      dataOut;

   // Every asynchronous input goes through two flops; idle level is high.
   always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
      if (!PIN_nRST) begin
         reqS1   <= '1;
         reqS2   <= '1;
         reqPrev <= '1;
         iakiS1  <= 1'b1;
         iakiS2  <= 1'b1;
         dinS1   <= 1'b1;
         dinS2   <= 1'b1;
      end else begin
         reqS1   <= PIN_nREQ;
         reqS2   <= reqS1;
         reqPrev <= reqS2;
         iakiS1  <= PIN_nIAKI;
         iakiS2  <= iakiS1;
         dinS1   <= PIN_nDIN;
         dinS2   <= dinS1;
      end
   end

   assign fall = reqPrev & ~reqS2;

`ifdef VIC_CSR_EN
   logic        syncS1, syncS2, syncPrev, doutS1, doutS2;
   logic [15:0] adS1, adS2;
   logic        csrSel, csrCycle, maskLoad;
   logic        unusedCsr;

   always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
      if (!PIN_nRST) begin
         syncS1   <= 1'b1;
         syncS2   <= 1'b1;
         syncPrev <= 1'b1;
         doutS1   <= 1'b1;
         doutS2   <= 1'b1;
         adS1     <= '1;
         adS2     <= '1;
      end else begin
         syncS1   <= PIN_nSYNC;
         syncS2   <= syncS1;
         syncPrev <= syncS2;
         doutS1   <= PIN_nDOUT;
         doutS2   <= doutS1;
         adS1     <= PIN_nAD_IN;
         adS2     <= adS1;
      end
   end

   // AD is synchronized alongside nSYNC, so the address is aligned with the strobe edge.
   always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
      if (!PIN_nRST) begin
         csrSel   <= 1'b0;
         csrCycle <= 1'b0;
         mask     <= '1;
      end else begin
         if (syncPrev && !syncS2)
            csrSel <= (~adS2[15:3] == CSR_ADR);
         else if (!syncPrev && syncS2)
            csrSel <= 1'b0;
         if (stateNext == CSR_RD)
            csrCycle <= 1'b1;
         else if (state == IDLE)
            csrCycle <= 1'b0;
         if (maskLoad)
            mask <= ~adS2[N-1:0];
      end
   end

   assign unusedCsr = ^adS2;
   assign dataOut   = csrCycle ? {8'(pend), 8'(mask)} : {8'h00, vecOf(VEC_BASE, win)};
`else
   logic unusedIn;
   assign unusedIn = ^{PIN_nSYNC, PIN_nDOUT, PIN_nAD_IN};
   assign mask     = '1;
   assign dataOut  = {8'h00, vecOf(VEC_BASE, win)};
`endif

   vic_prio_enc #(.N(N)) uEnc (
      .req   (pend & mask),
      .valid (encValid),
      .idx   (encIdx)
   );

   always_comb begin
      stateNext = state;
      ackSet    = '0;
      loadWin   = 1'b0;
`ifdef VIC_CSR_EN
      maskLoad  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!dinS2 && !iakiS2) begin
               loadWin   = encValid;
               stateNext = encValid ? VECT : PASS;
            end
`ifdef VIC_CSR_EN
            else if (csrSel && !dinS2)
               stateNext = CSR_RD;
            else if (csrSel && !doutS2) begin
               maskLoad  = 1'b1;
               stateNext = CSR_WR;
            end
`endif
         end
         VECT: stateNext = RPLY;
         RPLY: begin
            if (dinS2) begin
               stateNext = IDLE;
`ifdef VIC_CSR_EN
               if (!csrCycle)
`endif
               for (int unsigned i = 0; i < N; i++)
                  if (win == IDX_W'(i))
                     ackSet[i] = 1'b1;
            end
         end
         PASS: if (iakiS2) stateNext = IDLE;
`ifdef VIC_CSR_EN
         CSR_RD: stateNext = RPLY;
         CSR_WR: if (doutS2) stateNext = IDLE;
`endif
         default: stateNext = IDLE;
      endcase
   end

   // pend is cleared on the same edge the ACK pulse rises; a coincident new edge wins.
   always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
      if (!PIN_nRST) begin
         state    <= IDLE;
         pend     <= '0;
         ackReg   <= '0;
         nVirqReg <= 1'b1;
         win      <= '0;
      end else begin
         state    <= stateNext;
         pend     <= (pend & ~ackSet) | fall;
         ackReg   <= ackSet;
         nVirqReg <= ~|(pend & mask);
         if (loadWin)
            win <= encIdx;
      end
   end

   assign PIN_ACK     = ackReg;
   assign PIN_nVIRQ   = nVirqReg;
   assign PIN_AD_OE   = (state == VECT) || (state == RPLY) || (state == CSR_RD);
   assign PIN_nAD_OUT = PIN_AD_OE ? ~dataOut : '1;
   assign PIN_nRPLY   = !((state == RPLY) || (state == CSR_WR));
   assign PIN_nIAKO   = (state != PASS);

endmodule

// File: tb/tb_vic_qbus_arb.sv
module tb_vic_qbus_arb;

   logic        clk = 1'b0;
   logic        nRst;
   logic [3:0]  nReq;
   logic [3:0]  ack;
   logic        nVirq, nIaki, nIako, nSync, nDin, nDout, adOe, nRply;
   logic [15:0] nAdIn, nAdOut;

   int checks = 0;
   int errors = 0;
   int lat;

   always #5 clk = ~clk;

   vic_qbus_arb #(.N(4), .VEC_BASE(8'o060), .CSR_ADR(13'o17760)) dut (
      .PIN_CLK     (clk),
      .PIN_nRST    (nRst),
      .PIN_nREQ    (nReq),
      .PIN_ACK     (ack),
      .PIN_nVIRQ   (nVirq),
      .PIN_nIAKI   (nIaki),
      .PIN_nIAKO   (nIako),
      .PIN_nSYNC   (nSync),
      .PIN_nDIN    (nDin),
      .PIN_nDOUT   (nDout),
      .PIN_nAD_IN  (nAdIn),
      .PIN_nAD_OUT (nAdOut),
      .PIN_AD_OE   (adOe),
      .PIN_nRPLY   (nRply)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sync (2) + IDLE->VECT (1) + VECT->RPLY (1): ends with nRPLY low.
   task automatic iakStart();
      nDin  = 1'b0;
      nIaki = 1'b0;
      tick(4);
   endtask

   // nDIN high takes 2 sync clocks; ACK rises on the third edge.
   task automatic iakEnd();
      nIaki = 1'b1;
      nDin  = 1'b1;
      tick(3);
   endtask

   initial begin
      nRst  = 1'b0;
      nReq  = 4'hF;
      nIaki = 1'b1;
      nSync = 1'b1;
      nDin  = 1'b1;
      nDout = 1'b1;
      nAdIn = 16'hFFFF;
      #12;
      chk("rst_ack",   16'(ack), 16'h0000);
      chk("rst_nvirq", 16'(nVirq), 16'h0001);
      chk("rst_niako", 16'(nIako), 16'h0001);
      chk("rst_adoe",  16'(adOe), 16'h0000);
      chk("rst_nadout", nAdOut, 16'hFFFF);
      chk("rst_nrply", 16'(nRply), 16'h0001);
      nRst = 1'b1;
      tick(3);

      // Single request on channel 2.
      nReq[2] = 1'b0;
      tick(2);
      chk("t2_virq_early", 16'(nVirq), 16'h0001);
      lat = 2;
      while (nVirq === 1'b1 && lat < 8) begin
         tick(1);
         lat++;
      end
      chk("t2_virq_lat_ok", 16'(lat >= 3 && lat <= 4), 16'h0001);
      chk("t2_virq_low", 16'(nVirq), 16'h0000);
      nDin  = 1'b0;
      nIaki = 1'b0;
      tick(2);
      chk("t2_adoe_sync", 16'(adOe), 16'h0000);
      tick(1);
      chk("t2_adoe_vect", 16'(adOe), 16'h0001);
      chk("t2_vector", nAdOut, ~16'o070);
      chk("t2_nrply_vect", 16'(nRply), 16'h0001);
      tick(1);
      chk("t2_nrply", 16'(nRply), 16'h0000);
      chk("t2_niako_blocked", 16'(nIako), 16'h0001);
      // nIAKI released before nDIN: reply is held.
      nIaki = 1'b1;
      tick(3);
      chk("t2_hold_rply", 16'(nRply), 16'h0000);
      nDin = 1'b1;
      tick(2);
      chk("t2_ack_early", 16'(ack), 16'h0000);
      tick(1);
      chk("t2_ack", 16'(ack), 16'h0004);
      chk("t2_rply_rel", 16'(nRply), 16'h0001);
      chk("t2_adoe_rel", 16'(adOe), 16'h0000);
      chk("t2_nadout_rel", nAdOut, 16'hFFFF);
      tick(1);
      chk("t2_ack_pulse", 16'(ack), 16'h0000);
      chk("t2_virq_clear", 16'(nVirq), 16'h0001);
      nReq[2] = 1'b1;
      tick(3);

      // Channels 1 and 3 together: lowest index first.
      nReq[1] = 1'b0;
      nReq[3] = 1'b0;
      tick(4);
      chk("t3_virq", 16'(nVirq), 16'h0000);
      iakStart();
      chk("t3_vec1", nAdOut, ~16'o064);
      iakEnd();
      chk("t3_ack1", 16'(ack), 16'h0002);
      tick(1);
      chk("t3_virq_still", 16'(nVirq), 16'h0000);
      iakStart();
      chk("t3_vec3", nAdOut, ~16'o074);
      iakEnd();
      chk("t3_ack3", 16'(ack), 16'h0008);
      tick(1);
      chk("t3_virq_clear", 16'(nVirq), 16'h0001);
      nReq[1] = 1'b1;
      nReq[3] = 1'b1;
      tick(3);

      // Nothing pending: chain is passed on.
      nDin  = 1'b0;
      nIaki = 1'b0;
      tick(3);
      chk("t4_niako", 16'(nIako), 16'h0000);
      chk("t4_nrply", 16'(nRply), 16'h0001);
      chk("t4_adoe", 16'(adOe), 16'h0000);
      nIaki = 1'b1;
      nDin  = 1'b1;
      tick(2);
      chk("t4_niako_hold", 16'(nIako), 16'h0000);
      tick(1);
      chk("t4_niako_rel", 16'(nIako), 16'h0001);
      tick(2);

      // New edge on channel 0 in the clock of its ACK.
      nReq[0] = 1'b0;
      tick(4);
      chk("t5_virq", 16'(nVirq), 16'h0000);
      nReq[0] = 1'b1;
      iakStart();
      chk("t5_vec0", nAdOut, ~16'o060);
      nIaki   = 1'b1;
      nDin    = 1'b1;
      nReq[0] = 1'b0;
      tick(3);
      chk("t5_ack0", 16'(ack), 16'h0001);
      tick(1);
      chk("t5_virq_kept", 16'(nVirq), 16'h0000);
      nReq[0] = 1'b1;
      iakStart();
      chk("t5_vec0_again", nAdOut, ~16'o060);
      iakEnd();
      chk("t5_ack0_again", 16'(ack), 16'h0001);
      tick(1);
      chk("t5_virq_clear", 16'(nVirq), 16'h0001);
      tick(2);

`ifdef VIC_CSR_EN
      // Mask write, masked request, CSR read.
      nAdIn = ~16'o177600;
      nSync = 1'b0;
      tick(3);
      nAdIn = ~16'h000E;
      nDout = 1'b0;
      tick(3);
      chk("t6_wr_rply", 16'(nRply), 16'h0000);
      nDout = 1'b1;
      tick(3);
      chk("t6_wr_done", 16'(nRply), 16'h0001);
      nSync = 1'b1;
      nAdIn = 16'hFFFF;
      nReq[0] = 1'b0;
      tick(6);
      chk("t6_masked_virq", 16'(nVirq), 16'h0001);
      nAdIn = ~16'o177600;
      nSync = 1'b0;
      tick(3);
      nAdIn = 16'hFFFF;
      nDin  = 1'b0;
      tick(4);
      chk("t6_rd_rply", 16'(nRply), 16'h0000);
      chk("t6_rd_data", nAdOut, ~16'h010E);
      nDin = 1'b1;
      tick(3);
      chk("t6_rd_noack", 16'(ack), 16'h0000);
      chk("t6_rd_done", 16'(nRply), 16'h0001);
      nSync = 1'b1;
      nReq[0] = 1'b1;
      tick(3);
`endif

      // Reset in the middle of a reply.
      nReq[2] = 1'b0;
      tick(4);
      iakStart();
      chk("t1_nrply_pre", 16'(nRply), 16'h0000);
      #2;
      nRst = 1'b0;
      #1;
      chk("t1_nrply", 16'(nRply), 16'h0001);
      chk("t1_adoe", 16'(adOe), 16'h0000);
      chk("t1_nvirq", 16'(nVirq), 16'h0001);
      chk("t1_nadout", nAdOut, 16'hFFFF);
      nDin  = 1'b1;
      nIaki = 1'b1;
      nReq  = 4'hF;
      tick(1);
      nRst = 1'b1;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
